// File: rtl/rx_cnt_pkg.sv
// Shared types and constants for the multi-channel rxDone byte counter.
package rx_cnt_pkg;

  typedef enum logic {
    IDLE,
    HELD
  } snap_state_t;

  localparam int SAT_MODE     = 0;
  localparam int WRAP_MODE_ON = 1;
  localparam int MAX_CH       = 16;

  // Bits needed to hold a count of 0..n simultaneous channel edges.
  function automatic int pop_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rx_cnt_channel.sv
// One rxDone channel: rising-edge detect, saturating/wrapping counter and status flags.
module rx_cnt_channel
  import rx_cnt_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int MAX_COUNT = 65536,
  parameter int WRAP_MODE = SAT_MODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rx_done,
  input  logic             clr,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt,
  output logic             rise_q,
  output logic             sat,
  output logic             wrap_pulse,
  output logic             thresh_hit
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  logic prev;
  logic wrap_nxt;

  // Qualified edge also feeds the aggregate, even when clr or saturation drops it here.
  assign rise_q     = rx_done & ~prev & en;
  assign sat        = (count == MAX_C);
  assign thresh_hit = (count >= threshold);

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (rise_q) begin
      if (count < MAX_C) begin
        count_nxt = count + CNT_W'(1);
      end else if (WRAP_MODE == WRAP_MODE_ON) begin
        count_nxt = '0;
        wrap_nxt  = 1'b1;
      end
    end
  end

  // prev resets high so a line already asserted at reset release is not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev       <= 1'b1;
      count      <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      prev       <= rx_done;
      count      <= count_nxt;
      wrap_pulse <= wrap_nxt;
    end
  end

endmodule

// File: rtl/rx_byte_counter_mc.sv
// Multi-channel rxDone byte counter with aggregate total and coherent snapshot readout.
module rx_byte_counter_mc
  import rx_cnt_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int MAX_COUNT = 65536,
  parameter int WRAP_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       rx_done,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [CNT_W-1:0]        threshold,
  output logic [NUM_CH*CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0]        total_count,
  output logic [NUM_CH-1:0]       sat,
  output logic [NUM_CH-1:0]       wrap_pulse,
  output logic [NUM_CH-1:0]       thresh_hit,
  input  logic                    snap_req,
  output logic                    snap_valid,
  input  logic                    snap_ack,
  output logic [NUM_CH*CNT_W-1:0] snap_count,
  output logic [CNT_W-1:0]        snap_total
);

  localparam int POP_W = pop_w(NUM_CH);

  logic [NUM_CH*CNT_W-1:0] count_nxt_all;
  logic [NUM_CH-1:0]       rise;
  logic [POP_W-1:0]        pop;
  logic [CNT_W-1:0]        total_nxt;
  snap_state_t             state;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rx_cnt_channel #(
      .CNT_W    (CNT_W),
      .MAX_COUNT(MAX_COUNT),
      .WRAP_MODE(WRAP_MODE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .rx_done   (rx_done[i]),
      .clr       (clr[i]),
      .threshold (threshold),
      .count     (byte_count[i*CNT_W +: CNT_W]),
      .count_nxt (count_nxt_all[i*CNT_W +: CNT_W]),
      .rise_q    (rise[i]),
      .sat       (sat[i]),
      .wrap_pulse(wrap_pulse[i]),
      .thresh_hit(thresh_hit[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + POP_W'(rise[i]);
    end
  end

  assign total_nxt = total_count + CNT_W'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_count <= '0;
    end else begin
      total_count <= total_nxt;
    end
  end

  // Capture next-state values so the snapshot includes the request cycle's own updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      snap_valid <= 1'b0;
      snap_count <= '0;
      snap_total <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (snap_req) begin
            snap_count <= count_nxt_all;
            snap_total <= total_nxt;
            snap_valid <= 1'b1;
            state      <= HELD;
          end
        end
        HELD: begin
          if (snap_ack) begin
            snap_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          snap_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_byte_counter_mc.sv
// Scoreboard bench: saturate and wrap instances share stimulus; a reference model predicts every cycle.
module tb_rx_byte_counter_mc;

  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 16;
  localparam int MAX_COUNT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  rx_done = '0;
  logic [3:0]  clr = '0;
  logic [15:0] threshold = '0;
  logic        snap_req = 1'b0;
  logic        snap_ack = 1'b0;

  logic [63:0] byte_count [2];
  logic [15:0] total_count [2];
  logic [3:0]  sat [2];
  logic [3:0]  wrap_pulse [2];
  logic [3:0]  thresh_hit [2];
  logic        snap_valid [2];
  logic [63:0] snap_count [2];
  logic [15:0] snap_total [2];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    rx_byte_counter_mc #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .MAX_COUNT(MAX_COUNT),
      .WRAP_MODE(m)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .rx_done    (rx_done),
      .clr        (clr),
      .threshold  (threshold),
      .byte_count (byte_count[m]),
      .total_count(total_count[m]),
      .sat        (sat[m]),
      .wrap_pulse (wrap_pulse[m]),
      .thresh_hit (thresh_hit[m]),
      .snap_req   (snap_req),
      .snap_valid (snap_valid[m]),
      .snap_ack   (snap_ack),
      .snap_count (snap_count[m]),
      .snap_total (snap_total[m])
    );
  end

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bc [2];
    logic [15:0] tot [2];
    logic [3:0]  sat [2];
    logic [3:0]  wp [2];
    logic [3:0]  thr [2];
    logic        sv [2];
    logic [63:0] sc [2];
    logic [15:0] st [2];
  } exp_t;

  typedef struct {
    logic [63:0] sc;
    logic [15:0] st;
  } snap_t;

  exp_t  exp_q[$];
  snap_t snapq0[$];
  snap_t snapq1[$];

  int checks = 0;
  int failures = 0;

  // Reference state: plain integer counts per mode and channel.
  int cnt [2][4];
  int tot [2];
  int scnt [2][4];
  int stot [2];
  bit wp [2][4];
  bit held [2];
  bit prev [4];
  logic [15:0] thr = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic resetModel();
    for (int m = 0; m < 2; m++) begin
      tot[m] = 0;
      stot[m] = 0;
      held[m] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt[m][i] = 0;
        scnt[m][i] = 0;
        wp[m][i] = 1'b0;
      end
    end
    snapq0.delete();
    snapq1.delete();
  endtask

  task automatic doReset(input logic [3:0] rx);
    @(negedge clk);
    rst = 1'b0;
    rx_done = rx;
    en = 1'b0;
    clr = '0;
    snap_req = 1'b0;
    snap_ack = 1'b0;
    resetModel();
    #1;
    for (int m = 0; m < 2; m++) begin
      checkOutput($sformatf("m%0d reset snap_valid", m), 64'(snap_valid[m]), 64'd0);
      checkOutput($sformatf("m%0d reset byte_count", m), byte_count[m], 64'd0);
      checkOutput($sformatf("m%0d reset total", m), 64'(total_count[m]), 64'd0);
      checkOutput($sformatf("m%0d reset wrap_pulse", m), 64'(wrap_pulse[m]), 64'd0);
      checkOutput($sformatf("m%0d reset snap_count", m), snap_count[m], 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) prev[i] = rx[i];
  endtask

  task automatic applyStimulus(input logic [3:0] rx, input logic [3:0] c, input logic e,
                               input logic rq, input logic ak);
    exp_t  x;
    snap_t s;
    bit    q;
    @(negedge clk);
    rx_done = rx;
    clr = c;
    en = e;
    snap_req = rq;
    snap_ack = ak;
    threshold = thr;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        q = rx[i] && !prev[i] && e;
        wp[m][i] = 1'b0;
        if (q) tot[m] = (tot[m] + 1) % 65536;
        if (c[i]) cnt[m][i] = 0;
        else if (q) begin
          if (cnt[m][i] < MAX_COUNT) cnt[m][i] = cnt[m][i] + 1;
          else if (m == 1) begin
            cnt[m][i] = 0;
            wp[m][i] = 1'b1;
          end
        end
      end
      if (!held[m] && rq) begin
        held[m] = 1'b1;
        stot[m] = tot[m];
        for (int i = 0; i < 4; i++) scnt[m][i] = cnt[m][i];
        for (int i = 0; i < 4; i++) s.sc[i*16 +: 16] = 16'(scnt[m][i]);
        s.st = 16'(stot[m]);
        if (m == 0) snapq0.push_back(s);
        else snapq1.push_back(s);
      end else if (held[m] && ak) begin
        held[m] = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) prev[i] = rx[i];
    for (int m = 0; m < 2; m++) begin
      x.tot[m] = 16'(tot[m]);
      x.st[m] = 16'(stot[m]);
      x.sv[m] = held[m];
      for (int i = 0; i < 4; i++) begin
        x.bc[m][i*16 +: 16] = 16'(cnt[m][i]);
        x.sc[m][i*16 +: 16] = 16'(scnt[m][i]);
        x.sat[m][i] = (cnt[m][i] == MAX_COUNT);
        x.wp[m][i] = wp[m][i];
        x.thr[m][i] = (cnt[m][i] >= int'(thr));
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic pulseEdges(input logic [3:0] mask, input int n, input logic e);
    for (int k = 0; k < n; k++) begin
      applyStimulus(mask, 4'b0, e, 1'b0, 1'b0);
      applyStimulus(4'b0, 4'b0, e, 1'b0, 1'b0);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare each predicted cycle, and pop a snapshot whenever snap_valid rises.
  initial begin : monitor
    exp_t  x;
    snap_t s;
    bit    sv_last [2];
    sv_last[0] = 1'b0;
    sv_last[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        for (int m = 0; m < 2; m++) begin
          checkOutput($sformatf("m%0d byte_count", m), byte_count[m], x.bc[m]);
          checkOutput($sformatf("m%0d total_count", m), 64'(total_count[m]), 64'(x.tot[m]));
          checkOutput($sformatf("m%0d sat", m), 64'(sat[m]), 64'(x.sat[m]));
          checkOutput($sformatf("m%0d wrap_pulse", m), 64'(wrap_pulse[m]), 64'(x.wp[m]));
          checkOutput($sformatf("m%0d thresh_hit", m), 64'(thresh_hit[m]), 64'(x.thr[m]));
          checkOutput($sformatf("m%0d snap_valid", m), 64'(snap_valid[m]), 64'(x.sv[m]));
          checkOutput($sformatf("m%0d snap_count", m), snap_count[m], x.sc[m]);
          checkOutput($sformatf("m%0d snap_total", m), 64'(snap_total[m]), 64'(x.st[m]));
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (snap_valid[m] && !sv_last[m]) begin
          if ((m == 0 && snapq0.size() == 0) || (m == 1 && snapq1.size() == 0)) begin
            checks++;
            failures++;
            $display("[TB] FAIL m%0d snap_unexpected: snap_valid rose with no capture pending", m);
          end else begin
            s = (m == 0) ? snapq0.pop_front() : snapq1.pop_front();
            checkOutput($sformatf("m%0d snap_hs_count", m), snap_count[m], s.sc);
            checkOutput($sformatf("m%0d snap_hs_total", m), 64'(snap_total[m]), 64'(s.st));
          end
        end
        sv_last[m] = snap_valid[m];
      end
    end
  end

  initial begin : stimulus
    logic [3:0] rmask;
    logic [3:0] cmask;

    // Line already high at reset release must not count.
    doReset(4'b0001);
    for (int k = 0; k < 10; k++) applyStimulus(4'b0001, 4'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("plan ch0 after first rise", 64'(byte_count[0][15:0]), 64'd1);
    checkOutput("plan total after first rise", 64'(total_count[0]), 64'd1);

    // Saturation on ch1 (wrap instance runs past MAX in parallel).
    applyStimulus(4'b0000, 4'b0, 1'b1, 1'b0, 1'b0);
    pulseEdges(4'b0010, 7, 1'b1);
    settle();
    checkOutput("plan sat ch1 count", 64'(byte_count[0][31:16]), 64'd5);
    checkOutput("plan sat ch1 flag", 64'(sat[0][1]), 64'd1);
    checkOutput("plan sat total", 64'(total_count[0]), 64'd8);
    applyStimulus(4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0);

    // Wrap on ch2.
    pulseEdges(4'b0100, 6, 1'b1);
    settle();
    checkOutput("plan wrap ch2 count", 64'(byte_count[1][47:32]), 64'd0);

    // All channels together, enabled then disabled.
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b1111, 4'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0, 1'b1, 1'b0, 1'b0);

    // Clear coincident with an edge, then threshold crossing.
    pulseEdges(4'b1000, 3, 1'b1);
    applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0, 1'b1, 1'b0, 1'b0);
    thr = 16'd2;
    pulseEdges(4'b1000, 2, 1'b1);
    settle();
    checkOutput("plan thresh ch3", 64'(thresh_hit[0][3]), 64'd1);

    // Snapshot hold, live counting, ack, then reset while held.
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    pulseEdges(4'b0001, 3, 1'b1);
    applyStimulus(4'b0000, 4'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0, 1'b1, 1'b1, 1'b0);
    pulseEdges(4'b0001, 5, 1'b1);
    applyStimulus(4'b0001, 4'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(4'b0000, 4'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0, 1'b1, 1'b0, 1'b0);
    doReset(4'b0000);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      rmask = 4'($urandom);
      cmask = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 19) == 0) thr = 16'($urandom_range(0, 6));
      applyStimulus(rmask, cmask, ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      if (k == 300) doReset(4'($urandom));
    end

    applyStimulus(4'b0000, 4'b0, 1'b0, 1'b0, 1'b0);
    settle();
    settle();
    checkOutput("snapq0 drained", 64'(snapq0.size()), 64'd0);
    checkOutput("snapq1 drained", 64'(snapq1.size()), 64'd0);
    checkOutput("exp_q drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
